// File: rtl/tdc_count_seq.sv
// Sequencer for the TDC coarse up/down counter: clears it by counting down, measures
// start-to-stop clk cycles with saturation, cross-checks against a mirror, hands off the result.
module tdc_count_seq #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cnt_val,
  output logic             cnt_en,
  output logic             cnt_up_dnb,
  output logic             busy,
  output logic             armed,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_data,
  output logic             res_ovf,
  output logic             res_err
);

  localparam logic [CNT_W-1:0] MAX      = '1;
  localparam logic [CNT_W:0]   STEP_LIM = {1'b1, {CNT_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, CLR_CHK, CLR_STEP, ARMED, COUNT, SETTLE, DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] mirror;
  logic [CNT_W:0]   step;

  // NOTE: every register here is reset, and all state updates use non-blocking
  // assignments so each output changes exactly on the clock edge it is decided on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt_en     <= 1'b0;
      cnt_up_dnb <= 1'b1;
      busy       <= 1'b0;
      armed      <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ovf    <= 1'b0;
      res_err    <= 1'b0;
      mirror     <= '0;
      step       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state   <= CLR_CHK;
            busy    <= 1'b1;
            res_ovf <= 1'b0;
            res_err <= 1'b0;
            step    <= '0;
          end
        end
        CLR_CHK: begin
          if (cnt_val == '0) begin
            state  <= ARMED;
            armed  <= 1'b1;
            mirror <= '0;
          end else if (step == STEP_LIM) begin
            // Counter never reached zero: report a clear timeout.
            state     <= DONE;
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_data  <= '0;
          end else begin
            state      <= CLR_STEP;
            cnt_en     <= 1'b1;
            cnt_up_dnb <= 1'b0;
            step       <= step + 1'b1;
          end
        end
        CLR_STEP: begin
          // One-cycle pulse; cnt_val is re-checked only after the step has landed.
          cnt_en <= 1'b0;
          state  <= CLR_CHK;
        end
        ARMED: begin
          if (start) begin
            state      <= COUNT;
            armed      <= 1'b0;
            cnt_en     <= 1'b1;
            cnt_up_dnb <= 1'b1;
          end
        end
        COUNT: begin
          // cnt_en is high for the whole state, so the mirror steps with the counter.
          mirror <= mirror + 1'b1;
          if (mirror == MAX - 1'b1) begin
            cnt_en  <= 1'b0;
            res_ovf <= 1'b1;
            state   <= SETTLE;
          end else if (stop) begin
            cnt_en <= 1'b0;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          res_err   <= (cnt_val != mirror);
          res_data  <= mirror;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
